pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/perf_counter.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/control stage.
package pipe_ctrl_pkg;

   localparam int REG_IDX_W = 5;
   localparam int CNT_W     = 2;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [CNT_W-1:0]     lu_cnt_t;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } hz_state_t;

   localparam reg_idx_t XZR_IDX_DEFAULT = reg_idx_t'(31);
   localparam lu_cnt_t  CNT_ONE         = lu_cnt_t'(1);

endpackage

// File: rtl/perf_counter.sv
// 32-bit wrapping event counter; advances by one on each clock with en_i high.
module perf_counter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en_i,
   output logic [31:0] count_o
);

   logic [31:0] count_q, count_d;

   assign count_d = en_i ? count_q + 32'd1 : count_q;
   assign count_o = count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: valid-bit tracking, load-use stall FSM, branch flush, global freeze.
// Define PIPE_HAZARD_PERF_EN to add the stall/flush/retire performance counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter reg_idx_t XZR_IDX         = XZR_IDX_DEFAULT,
   parameter int       LOAD_USE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fetch_valid,
   input  reg_idx_t    id_rs1,
   input  reg_idx_t    id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  reg_idx_t    id_rd,
   input  logic        id_is_load,
   input  logic        id_reg_write,
   input  logic        br_taken,
   input  logic        ext_stall,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        id_valid,
   output logic        ex_valid,
   output logic        mem_valid,
   output logic        wb_valid,
   output logic        wb_reg_write_en,
   output logic        lu_stall,
`ifdef PIPE_HAZARD_PERF_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count,
   output logic [31:0] retired,
`endif
   output hz_state_t   dbg_state,
   output lu_cnt_t     dbg_cnt
);

   hz_state_t state_q, state_d;
   lu_cnt_t   cnt_q, cnt_d;

   logic      id_valid_q, ex_valid_q, mem_valid_q, wb_valid_q;
   logic      id_valid_d, ex_valid_d;
   reg_idx_t  ex_rd_q;
   logic      ex_is_load_q, ex_reg_write_q, mem_reg_write_q, wb_reg_write_q;
   logic      hz, lu_active;

   // A load in EX blocks a dependent ID instruction until forwarding can cover it.
   assign hz = ex_valid_q & ex_is_load_q & (ex_rd_q != XZR_IDX) & id_valid_q &
               ((id_uses_rs1 & (id_rs1 == ex_rd_q)) | (id_uses_rs2 & (id_rs2 == ex_rd_q)));
   assign lu_active = (state_q == LU_STALL) | hz;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!ext_stall) begin
         if (br_taken) begin
            state_d = RUN;
            cnt_d   = '0;
         end else begin
            case (state_q)
               RUN: begin
                  if (hz && (LOAD_USE_CYCLES > 1)) begin
                     state_d = LU_STALL;
                     cnt_d   = lu_cnt_t'(LOAD_USE_CYCLES - 1);
                  end
               end
               LU_STALL: begin
                  if (cnt_q == CNT_ONE) begin
                     state_d = RUN;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q - CNT_ONE;
                  end
               end
               default: begin
                  state_d = RUN;
                  cnt_d   = '0;
               end
            endcase
         end
      end
   end

   // Priority: reset, then global freeze, then branch flush, then load-use stall.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      lu_stall    = 1'b0;
      if (!reset_n || ext_stall) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
      end else if (br_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (lu_active) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
         lu_stall    = 1'b1;
      end
   end

   assign ex_valid_d = idex_bubble ? 1'b0 : id_valid_q;
   assign id_valid_d = ifid_flush ? 1'b0 : (ifid_en ? fetch_valid : id_valid_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         id_valid_q      <= 1'b0;
         ex_valid_q      <= 1'b0;
         mem_valid_q     <= 1'b0;
         wb_valid_q      <= 1'b0;
         ex_rd_q         <= '0;
         ex_is_load_q    <= 1'b0;
         ex_reg_write_q  <= 1'b0;
         mem_reg_write_q <= 1'b0;
         wb_reg_write_q  <= 1'b0;
      end else if (!ext_stall) begin
         id_valid_q      <= id_valid_d;
         ex_valid_q      <= ex_valid_d;
         mem_valid_q     <= ex_valid_q;
         wb_valid_q      <= mem_valid_q;
         ex_rd_q         <= id_rd;
         ex_is_load_q    <= id_is_load;
         ex_reg_write_q  <= id_reg_write;
         mem_reg_write_q <= ex_reg_write_q;
         wb_reg_write_q  <= mem_reg_write_q;
      end
   end

   assign id_valid        = id_valid_q;
   assign ex_valid        = ex_valid_q;
   assign mem_valid       = mem_valid_q;
   assign wb_valid        = wb_valid_q;
   assign wb_reg_write_en = wb_valid_q & wb_reg_write_q;
   assign dbg_state       = state_q;
   assign dbg_cnt         = cnt_q;

`ifdef PIPE_HAZARD_PERF_EN
   perf_counter u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (lu_stall & ~ext_stall),
      .count_o (stall_cycles)
   );

   perf_counter u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (br_taken & ~ext_stall),
      .count_o (flush_count)
   );

   perf_counter u_retire_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (wb_valid_q & ~ext_stall),
      .count_o (retired)
   );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances with LOAD_USE_CYCLES = 1, 2, 3
// share one stimulus stream; each scenario checks the instance it targets.
module tb_pipe_hazard_ctrl;
   import pipe_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       fetch_valid;
   reg_idx_t   id_rs1, id_rs2, id_rd;
   logic       id_uses_rs1, id_uses_rs2, id_is_load, id_reg_write;
   logic       br_taken, ext_stall;

   logic [2:0] pc_en, ifid_en, ifid_flush, idex_bubble;
   logic [2:0] id_valid, ex_valid, mem_valid, wb_valid, wb_reg_write_en, lu_stall;
   hz_state_t  dbg_state [3];
   lu_cnt_t    dbg_cnt [3];
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cycles [3];
   logic [31:0] flush_count [3];
   logic [31:0] retired [3];
`endif

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q [$];

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   for (genvar g = 0; g < 3; g++) begin : g_dut
      pipe_hazard_ctrl #(
         .XZR_IDX         (reg_idx_t'(31)),
         .LOAD_USE_CYCLES (g + 1)
      ) u_dut (
         .clk             (clk),
         .reset_n         (reset_n),
         .fetch_valid     (fetch_valid),
         .id_rs1          (id_rs1),
         .id_rs2          (id_rs2),
         .id_uses_rs1     (id_uses_rs1),
         .id_uses_rs2     (id_uses_rs2),
         .id_rd           (id_rd),
         .id_is_load      (id_is_load),
         .id_reg_write    (id_reg_write),
         .br_taken        (br_taken),
         .ext_stall       (ext_stall),
         .pc_en           (pc_en[g]),
         .ifid_en         (ifid_en[g]),
         .ifid_flush      (ifid_flush[g]),
         .idex_bubble     (idex_bubble[g]),
         .id_valid        (id_valid[g]),
         .ex_valid        (ex_valid[g]),
         .mem_valid       (mem_valid[g]),
         .wb_valid        (wb_valid[g]),
         .wb_reg_write_en (wb_reg_write_en[g]),
         .lu_stall        (lu_stall[g]),
`ifdef PIPE_HAZARD_PERF_EN
         .stall_cycles    (stall_cycles[g]),
         .flush_count     (flush_count[g]),
         .retired         (retired[g]),
`endif
         .dbg_state       (dbg_state[g]),
         .dbg_cnt         (dbg_cnt[g])
      );
   end

   // scoreboard check
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      fetch_valid  = 1'b0;
      id_rs1       = '0;
      id_rs2       = '0;
      id_rd        = '0;
      id_uses_rs1  = 1'b0;
      id_uses_rs2  = 1'b0;
      id_is_load   = 1'b0;
      id_reg_write = 1'b0;
      br_taken     = 1'b0;
      ext_stall    = 1'b0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   // Leaves a load (rd) in EX and a non-load instruction (rd=6) in ID.
   task automatic prime_load(input reg_idx_t rd);
      apply_reset();
      fetch_valid = 1'b1;
      tick();
      id_is_load   = 1'b1;
      id_rd        = rd;
      id_reg_write = 1'b1;
      tick();
      id_is_load   = 1'b0;
      id_rd        = reg_idx_t'(6);
      id_reg_write = 1'b1;
   endtask

   // Counts consecutive lu_stall cycles on instance k; every stalled edge must push a bubble.
   task automatic count_stall(input int k, output int n);
      n = 0;
      for (int c = 0; c < 8; c++) begin
         #2;
         if (!lu_stall[k]) break;
         n++;
         tick();
         check_eq("stall_ex_bubble", 32'(ex_valid[k]), 32'd0);
      end
   endtask

   initial begin
      int n;
      clear_inputs();

      // reset state, fetch_valid high must not leak through
      fetch_valid = 1'b1;
      tick();
      check_eq("rst_pc_en", 32'(pc_en), 32'd0);
      check_eq("rst_ifid_en", 32'(ifid_en), 32'd0);
      check_eq("rst_ifid_flush", 32'(ifid_flush), 32'd0);
      check_eq("rst_idex_bubble", 32'(idex_bubble), 32'd0);
      check_eq("rst_lu_stall", 32'(lu_stall), 32'd0);
      check_eq("rst_wb_rwe", 32'(wb_reg_write_en), 32'd0);
      check_eq("rst_valids", {20'd0, id_valid, ex_valid, mem_valid, wb_valid}, 32'd0);
      check_eq("rst_state", 32'(dbg_state[2]), 32'(RUN));

      // straight-line fetch: wb_valid rises on the 4th edge
      @(negedge clk);
      reset_n      = 1'b1;
      fetch_valid  = 1'b1;
      id_reg_write = 1'b1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd7);
      for (int i = 0; i < 4; i++) begin
         #2;
         check_eq("fetch_pc_en", 32'(pc_en), 32'd7);
         tick();
         check_eq("fetch_wb_valid", 32'(wb_valid), exp_q.pop_front());
      end
      check_eq("fetch_wb_rwe", 32'(wb_reg_write_en), 32'd7);
      id_reg_write = 1'b0;
      repeat (3) tick();
      check_eq("nowrite_wb_valid", 32'(wb_valid), 32'd7);
      check_eq("nowrite_wb_rwe", 32'(wb_reg_write_en), 32'd0);
`ifdef PIPE_HAZARD_PERF_EN
      check_eq("perf_retired", retired[0], 32'd3);
`endif

      // load-use on rs1: LOAD_USE_CYCLES bubbles, then the dependent enters EX
      for (int k = 0; k < 3; k++) begin
         prime_load(reg_idx_t'(5));
         id_uses_rs1 = 1'b1;
         id_rs1      = reg_idx_t'(5);
         #2;
         check_eq("lu_pc_en", 32'(pc_en[k]), 32'd0);
         check_eq("lu_ifid_en", 32'(ifid_en[k]), 32'd0);
         check_eq("lu_bubble", 32'(idex_bubble[k]), 32'd1);
         count_stall(k, n);
         check_eq("lu_stall_len", 32'(n), 32'(k + 1));
         tick();
         check_eq("lu_dep_in_ex", 32'(ex_valid[k]), 32'd1);
      end

      // rs2 dependency also stalls
      prime_load(reg_idx_t'(5));
      id_uses_rs2 = 1'b1;
      id_rs2      = reg_idx_t'(5);
      #2;
      check_eq("lu_rs2_stall", 32'(lu_stall), 32'd7);

      // destination is the zero register: no hazard
      prime_load(reg_idx_t'(31));
      id_uses_rs1 = 1'b1;
      id_rs1      = reg_idx_t'(31);
      #2;
      check_eq("xzr_no_stall", 32'(lu_stall), 32'd0);
      check_eq("xzr_pc_en", 32'(pc_en), 32'd7);

      // matching index but operand not read: no hazard
      prime_load(reg_idx_t'(5));
      id_rs1      = reg_idx_t'(5);
      id_uses_rs2 = 1'b1;
      id_rs2      = reg_idx_t'(7);
      #2;
      check_eq("unused_no_stall", 32'(lu_stall), 32'd0);

      // branch during LU_STALL (3-cycle instance)
      prime_load(reg_idx_t'(5));
      id_uses_rs1 = 1'b1;
      id_rs1      = reg_idx_t'(5);
      tick();
      check_eq("br_pre_state", 32'(dbg_state[2]), 32'(LU_STALL));
      check_eq("br_pre_cnt", 32'(dbg_cnt[2]), 32'd2);
      br_taken = 1'b1;
      #2;
      check_eq("br_flush", 32'(ifid_flush[2]), 32'd1);
      check_eq("br_bubble", 32'(idex_bubble[2]), 32'd1);
      check_eq("br_pc_en", 32'(pc_en[2]), 32'd1);
      check_eq("br_lu_stall", 32'(lu_stall[2]), 32'd0);
      tick();
      br_taken    = 1'b0;
      id_uses_rs1 = 1'b0;
      check_eq("br_id_valid", 32'(id_valid[2]), 32'd0);
      check_eq("br_ex_valid", 32'(ex_valid[2]), 32'd0);
      check_eq("br_state", 32'(dbg_state[2]), 32'(RUN));
      check_eq("br_cnt", 32'(dbg_cnt[2]), 32'd0);
      #2;
      check_eq("br_after_lu", 32'(lu_stall[2]), 32'd0);
      check_eq("br_after_flush", 32'(ifid_flush[2]), 32'd0);
`ifdef PIPE_HAZARD_PERF_EN
      check_eq("perf_flush", flush_count[2], 32'd1);
      check_eq("perf_br_stall", stall_cycles[2], 32'd1);
`endif

      // ext_stall freeze for 3 cycles inside a 3-cycle load-use stall
      prime_load(reg_idx_t'(5));
      id_uses_rs1 = 1'b1;
      id_rs1      = reg_idx_t'(5);
      tick();
      ext_stall = 1'b1;
      #2;
      check_eq("frz_pc_en", 32'(pc_en[2]), 32'd0);
      check_eq("frz_bubble", 32'(idex_bubble[2]), 32'd0);
      check_eq("frz_flush", 32'(ifid_flush[2]), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("frz_valids", {28'd0, id_valid[2], ex_valid[2], mem_valid[2], wb_valid[2]}, 32'hA);
         check_eq("frz_cnt", 32'(dbg_cnt[2]), 32'd2);
         check_eq("frz_state", 32'(dbg_state[2]), 32'(LU_STALL));
      end
`ifdef PIPE_HAZARD_PERF_EN
      check_eq("perf_frz_stall", stall_cycles[2], 32'd1);
`endif
      ext_stall = 1'b0;
      count_stall(2, n);
      check_eq("frz_remaining", 32'(n), 32'd2);
      tick();
      check_eq("frz_dep_in_ex", 32'(ex_valid[2]), 32'd1);
`ifdef PIPE_HAZARD_PERF_EN
      check_eq("perf_total_stall", stall_cycles[2], 32'd3);
`endif

      // reset in the middle of LU_STALL
      prime_load(reg_idx_t'(5));
      id_uses_rs1 = 1'b1;
      id_rs1      = reg_idx_t'(5);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("midrst_state", 32'(dbg_state[2]), 32'(RUN));
      check_eq("midrst_lu", 32'(lu_stall[2]), 32'd0);
      check_eq("midrst_pc_en", 32'(pc_en[2]), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #2;
      check_eq("postrst_lu", 32'(lu_stall[2]), 32'd0);
      check_eq("postrst_pc_en", 32'(pc_en[2]), 32'd1);
      tick();
      #2;
      check_eq("postrst_lu2", 32'(lu_stall[2]), 32'd0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
